// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU with multiply/divide.
// Contents:
//   ALU_*       4-bit operation codes driven on alucont
//   md_state_e  state encoding of the iterative multiply/divide unit
//   is_md_op    true for codes that launch a multiply/divide operation
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_ANDN  = 4'b0100;
  localparam logic [3:0] ALU_ORN   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b1001;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1011;
  localparam logic [3:0] ALU_MULT  = 4'b1100;
  localparam logic [3:0] ALU_MULTU = 4'b1101;
  localparam logic [3:0] ALU_DIV   = 4'b1110;
  localparam logic [3:0] ALU_DIVU  = 4'b1111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic is_md_op(input logic [3:0] alucont);
    return alucont[3:2] == 2'b11;
  endfunction

endpackage

// File: rtl/alu_md_md_unit.sv
// Iterative multiply/divide unit writing HI/LO after WIDTH cycles.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        launch request, honoured in IDLE and DONE only
//   op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b         operands, latched on an accepted start
//   busy         iterating
//   done         one-cycle pulse after HI/LO update
//   hi, lo       result registers, held between operations
module md_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  // hw/lw: working pair; accumulator:multiplier or remainder:dividend/quotient
  logic [WIDTH-1:0] opb_q, opb_d, hw_q, hw_d, lw_q, lw_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // Sign handling: iterate on magnitudes, fix signs on the final edge
  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // One iteration of shift-add multiply or restoring divide
  logic [WIDTH:0]   mul_sum, div_rem, div_diff;
  logic [WIDTH-1:0] hw_step, lw_step;

  always_comb begin
    mul_sum  = {1'b0, hw_q} + (lw_q[0] ? {1'b0, opb_q} : '0);
    div_rem  = {hw_q, lw_q[WIDTH-1]};
    div_diff = div_rem - {1'b0, opb_q};
    if (op_q[1]) begin
      // Remainder stays below the divisor, so bit WIDTH of the difference is its sign
      if (div_diff[WIDTH]) begin
        hw_step = div_rem[WIDTH-1:0];
        lw_step = {lw_q[WIDTH-2:0], 1'b0};
      end else begin
        hw_step = div_diff[WIDTH-1:0];
        lw_step = {lw_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      hw_step = mul_sum[WIDTH:1];
      lw_step = {mul_sum[0], lw_q[WIDTH-1:1]};
    end
  end

  // Signed result from the last iteration
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  always_comb begin
    prod = {hw_step, lw_step};
    if (op_q[1]) begin
      fin_lo = (sa_q ^ sb_q) ? -lw_step : lw_step;
      fin_hi = sa_q ? -hw_step : hw_step;
      // Divide by zero: quotient all ones; remainder already equals the dividend
      if (opb_q == '0) begin
        fin_lo = '1;
      end
    end else begin
      if (sa_q ^ sb_q) begin
        prod = -prod;
      end
      fin_hi = prod[2*WIDTH-1:WIDTH];
      fin_lo = prod[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    opb_d   = opb_q;
    hw_d    = hw_q;
    lw_d    = lw_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      MD_IDLE, MD_DONE: begin
        state_d = MD_IDLE;
        if (start) begin
          state_d = MD_RUN;
          cnt_d   = CntW'(WIDTH);
          op_d    = op;
          sa_d    = a_neg;
          sb_d    = b_neg;
          opb_d   = b_mag;
          hw_d    = '0;
          lw_d    = a_mag;
        end
      end
      MD_RUN: begin
        hw_d  = hw_step;
        lw_d  = lw_step;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          state_d = MD_DONE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opb_q   <= '0;
      hw_q    <= '0;
      lw_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opb_q   <= opb_d;
      hw_q    <= hw_d;
      lw_q    <= lw_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == MD_RUN);
  assign done = (state_q == MD_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_md.sv
// Multi-cycle datapath ALU: combinational logic/arith/compare/shift path
// plus an iterative multiply/divide unit with HI/LO registers.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   a, b                operands (rs, rt/imm)
//   alucont             operation select (ALU_* codes)
//   shamt               shift amount for SLL/SRL/SRA of b
//   md_start            launch the MD op selected by alucont
//   result, zero        combinational result and result==0
//   overflow            signed overflow of ADD/SUB, else 0
//   md_busy, md_done    MD unit iterating / one-cycle completion pulse
//   hi, lo              HI/LO registers
module alu_md
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alucont,
  input  logic [SHW-1:0]   shamt,
  input  logic             md_start,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned Msb = WIDTH - 1;

  logic [WIDTH-1:0] sum, diff;
  logic             ovf_add, ovf_sub, slt, sltu;

  assign sum     = a + b;
  assign diff    = a - b;
  assign ovf_add = (a[Msb] == b[Msb]) && (sum[Msb] != a[Msb]);
  assign ovf_sub = (a[Msb] != b[Msb]) && (diff[Msb] != a[Msb]);
  // True signed less-than even when the subtraction overflows
  assign slt     = diff[Msb] ^ ovf_sub;
  assign sltu    = (a < b);

  always_comb begin
    result = '0;
    case (alucont)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD:  result = sum;
      ALU_XOR:  result = a ^ b;
      ALU_ANDN: result = a & ~b;
      ALU_ORN:  result = a | ~b;
      ALU_SUB:  result = diff;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
      ALU_SLTU: result = {{(WIDTH-1){1'b0}}, sltu};
      ALU_SLL:  result = b << shamt;
      ALU_SRL:  result = b >> shamt;
      ALU_SRA:  result = $signed(b) >>> shamt;
      default:  result = '0;
    endcase
  end

  assign overflow = (alucont == ALU_ADD) ? ovf_add :
                    (alucont == ALU_SUB) ? ovf_sub : 1'b0;
  assign zero     = ~|result;

  logic md_go;
  assign md_go = md_start & is_md_op(alucont);

  md_unit #(
    .WIDTH(WIDTH)
  ) u_md_unit (
    .clk  (clk),
    .rst  (rst),
    .start(md_go),
    .op   (alucont[1:0]),
    .a    (a),
    .b    (b),
    .busy (md_busy),
    .done (md_done),
    .hi   (hi),
    .lo   (lo)
  );

endmodule

// File: tb/tb_alu_md.sv
module tb_alu_md;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit instance
  logic [31:0] a32, b32, res32, hi32, lo32;
  logic [3:0]  alu32;
  logic [4:0]  sh32;
  logic        st32, z32, ov32, busy32, done32;

  // 8-bit instance
  logic [7:0] a8, b8, res8, hi8, lo8;
  logic [3:0] alu8;
  logic [2:0] sh8;
  logic       st8, z8, ov8, busy8, done8;

  alu_md #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .a(a32), .b(b32), .alucont(alu32), .shamt(sh32),
    .md_start(st32), .result(res32), .zero(z32), .overflow(ov32),
    .md_busy(busy32), .md_done(done32), .hi(hi32), .lo(lo32)
  );

  alu_md #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .alucont(alu8), .shamt(sh8),
    .md_start(st8), .result(res8), .zero(z8), .overflow(ov8),
    .md_busy(busy8), .md_done(done8), .hi(hi8), .lo(lo8)
  );

  int checks = 0;
  int errors = 0;

  logic [63:0] q32[$];
  logic [15:0] q8[$];
  logic [63:0] e32;
  logic [15:0] e8;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: pop one expected {hi,lo} per md_done pulse
  initial forever begin
    @(negedge clk);
    if (done32) begin
      checks++;
      if (q32.size() == 0) begin
        errors++;
        $display("FAIL md32 unexpected done: got hi=%h lo=%h expected no pulse", hi32, lo32);
      end else begin
        e32 = q32.pop_front();
        if ({hi32, lo32} !== e32) begin
          errors++;
          $display("FAIL md32 hi/lo: got %h_%h expected %h_%h", hi32, lo32, e32[63:32], e32[31:0]);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done8) begin
      checks++;
      if (q8.size() == 0) begin
        errors++;
        $display("FAIL md8 unexpected done: got hi=%h lo=%h expected no pulse", hi8, lo8);
      end else begin
        e8 = q8.pop_front();
        if ({hi8, lo8} !== e8) begin
          errors++;
          $display("FAIL md8 hi/lo: got %h_%h expected %h_%h", hi8, lo8, e8[15:8], e8[7:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic comb(input string name, input logic [3:0] op, input logic [31:0] av,
                      input logic [31:0] bv, input logic [4:0] sh, input logic [31:0] er,
                      input logic ez, input logic eo);
    alu32 = op; a32 = av; b32 = bv; sh32 = sh;
    #1;
    chk({name, " result"}, res32, er);
    chk({name, " zero"}, z32, ez);
    chk({name, " overflow"}, ov32, eo);
  endtask

  // Pulse md_start for one edge; operands are scrambled afterwards
  task automatic issue(input bit w8, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic [63:0] exp, input bit push);
    @(posedge clk); #1;
    if (w8) begin
      alu8 = op; a8 = av[7:0]; b8 = bv[7:0]; st8 = 1'b1;
      if (push) q8.push_back(exp[15:0]);
    end else begin
      alu32 = op; a32 = av; b32 = bv; st32 = 1'b1;
      if (push) q32.push_back(exp);
    end
    @(posedge clk); #1;
    st8 = 1'b0; st32 = 1'b0;
    a8 = ~a8; b8 = 8'h5A; a32 = ~a32; b32 = 32'h1234_5678;
  endtask

  // Counts busy cycles until md_done; returns -1 if done never arrives
  task automatic wait_md(input bit w8, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (w8 ? done8 : done32) seen = 1'b1;
      else if (w8 ? busy8 : busy32) n++;
    end
    if (!seen) n = -1;
  endtask

  task automatic md(input string name, input bit w8, input logic [3:0] op,
                    input logic [31:0] av, input logic [31:0] bv, input logic [63:0] exp);
    int n;
    issue(w8, op, av, bv, exp, 1'b1);
    wait_md(w8, n);
    chk({name, " latency"}, 64'(n), w8 ? 64'd8 : 64'd32);
  endtask

  int n;

  initial begin
    rst = 1'b1;
    a32 = '0; b32 = '0; alu32 = ALU_AND; sh32 = '0; st32 = 1'b0;
    a8 = '0; b8 = '0; alu8 = ALU_AND; sh8 = '0; st8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy32, 0);
    chk("reset done", done32, 0);
    chk("reset hilo", {hi32, lo32}, 0);
    chk("reset hilo8", {hi8, lo8}, 0);
    rst = 1'b0;

    comb("add ovf",      ALU_ADD,  32'h7FFF_FFFF, 32'h1,         0,  32'h8000_0000, 0, 1);
    comb("add",          ALU_ADD,  32'd2,         32'd3,         0,  32'd5,         0, 0);
    comb("sub zero",     ALU_SUB,  32'd5,         32'd5,         0,  32'd0,         1, 0);
    comb("sub ovf",      ALU_SUB,  32'h8000_0000, 32'h1,         0,  32'h7FFF_FFFF, 0, 1);
    comb("slt neg",      ALU_SLT,  32'hFFFF_FFFF, 32'h1,         0,  32'd1,         0, 0);
    comb("sltu",         ALU_SLTU, 32'hFFFF_FFFF, 32'h1,         0,  32'd0,         1, 0);
    comb("slt wrap",     ALU_SLT,  32'h8000_0000, 32'h1,         0,  32'd1,         0, 0);
    comb("slt pos",      ALU_SLT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 0,  32'd0,         1, 0);
    comb("sra",          ALU_SRA,  32'h0,         32'h8000_0000, 4,  32'hF800_0000, 0, 0);
    comb("sll",          ALU_SLL,  32'h0,         32'h1,         31, 32'h8000_0000, 0, 0);
    comb("srl",          ALU_SRL,  32'h0,         32'h8000_0000, 31, 32'h1,         0, 0);
    comb("and",          ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 0,  32'hF000_F000, 0, 0);
    comb("or",           ALU_OR,   32'hF0F0_F0F0, 32'h0F00_000F, 0,  32'hFFF0_F0FF, 0, 0);
    comb("xor",          ALU_XOR,  32'hFFFF_0000, 32'h0FF0_0FF0, 0,  32'hF00F_0FF0, 0, 0);
    comb("xor no ovf",   ALU_XOR,  32'h7FFF_FFFF, 32'h1,         0,  32'h7FFF_FFFE, 0, 0);
    comb("andn",         ALU_ANDN, 32'h0000_00FF, 32'h0000_000F, 0,  32'h0000_00F0, 0, 0);
    comb("orn",          ALU_ORN,  32'h0,         32'hFFFF_FFF0, 0,  32'h0000_000F, 0, 0);
    comb("mult code",    ALU_MULT, 32'd3,         32'd7,         0,  32'd0,         1, 0);

    // md_start with a non-MD code is ignored
    @(posedge clk); #1;
    alu32 = ALU_ADD; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    chk("non-md start busy", busy32, 0);

    md("mult",       0, ALU_MULT,  32'hFFFF_FFFD, 32'd7,         {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    md("multu",      0, ALU_MULTU, 32'hFFFF_FFFF, 32'd2,         {32'h1,         32'hFFFF_FFFE});
    md("mult negneg",0, ALU_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, {32'h0,         32'hF});
    md("div",        0, ALU_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    md("div negb",   0, ALU_DIV,   32'd7,         32'hFFFF_FFFE, {32'h1,         32'hFFFF_FFFD});
    md("divu by 0",  0, ALU_DIVU,  32'd7,         32'd0,         {32'h7,         32'hFFFF_FFFF});
    md("div by 0",   0, ALU_DIV,   32'hFFFF_FFFB, 32'd0,         {32'hFFFF_FFFB, 32'hFFFF_FFFF});
    md("div ovf",    0, ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'h0,         32'h8000_0000});
    md("divu",       0, ALU_DIVU,  32'd100,       32'd7,         {32'd2,         32'd14});

    // Start during RUN is ignored; start in the DONE cycle is accepted
    issue(0, ALU_MULTU, 32'h1_0000, 32'h1_0000, {32'h1, 32'h0}, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    alu32 = ALU_DIVU; a32 = 32'd9; b32 = 32'd3; st32 = 1'b1;
    @(posedge clk); #1;
    st32 = 1'b0;
    wait_md(0, n);
    chk("b2b first done seen", 64'(n != -1), 1);
    alu32 = ALU_DIVU; a32 = 32'd100; b32 = 32'd7; st32 = 1'b1;
    q32.push_back({32'd2, 32'd14});
    @(posedge clk); #1;
    st32 = 1'b0; a32 = '0; b32 = '0;
    wait_md(0, n);
    chk("b2b second latency", 64'(n), 32);

    // Reset in the middle of a divide: no trace, no done pulse
    issue(0, ALU_DIV, 32'hFFFF_FFF9, 32'd2, 64'd0, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort busy", busy32, 0);
    chk("abort done", done32, 0);
    chk("abort hilo", {hi32, lo32}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("abort idle", busy32, 0);
    chk("abort hilo held", {hi32, lo32}, 0);

    md("w8 mult",    1, ALU_MULT,  32'hFD, 32'h07, 64'hFFEB);
    md("w8 multu",   1, ALU_MULTU, 32'hFF, 32'h02, 64'h01FE);
    md("w8 div",     1, ALU_DIV,   32'hF9, 32'h02, 64'hFFFD);
    md("w8 divu 0",  1, ALU_DIVU,  32'h07, 32'h00, 64'h07FF);
    md("w8 div ovf", 1, ALU_DIV,   32'h80, 32'hFF, 64'h0080);

    repeat (3) @(posedge clk);
    chk("scoreboard drained", 64'(q32.size() + q8.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
